mem_read_arbiter: RTL and testbench
===================================

MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, 32, read address width.
REQ-002 Parameter DATA_WIDTH, 32, read data width.
REQ-003 Parameter SB_MAX_WAIT, 16, demand grants the stream buffer may lose consecutively before it is forced to win.
REQ-004 Clock and reset SHALL be one clock, clk, with asynchronous active-low reset rst_n.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 <p>_arvalid  in  1  request pending, for each <p> in {ic, dc, sb} (I-cache refill, D-cache refill, stream-buffer prefetch).
REQ-008 <p>_araddr  in  ADDR_WIDTH  request start address.
REQ-009 <p>_arlen  in  8  beats minus one.
REQ-010 <p>_arready  out  1  one-cycle accept pulse.
REQ-011 <p>_rvalid  out  1  data beat for requester <p>.
REQ-012 <p>_rlast  out  1  final beat of the burst.
REQ-013 rdata  out  DATA_WIDTH  shared beat data, qualified per requester by <p>_rvalid.
REQ-014 sb_abort  in  1  stream buffer discards its in-flight prefetch.
REQ-015 m_araddr / m_arlen / m_arid  out  ADDR_WIDTH / 8 / 4  memory read address channel.
REQ-016 m_arvalid  out  1;  m_arready  in  1  address handshake.
REQ-017 m_rvalid  in  1;  m_rdata  in  DATA_WIDTH;  m_rready  out  1  memory read data channel.

Function
REQ-018 FSM states SHALL be IDLE, ADDR, DATA; reset state IDLE.
REQ-019 IDLE with any <p>_arvalid: winner chosen combinationally, its <p>_arready=1 that cycle; address, length, owner latched; next state ADDR.
REQ-020 Priority: ic/dc round-robin (pointer flips to the other after each demand grant, reset points to ic); sb wins only if ic_arvalid=dc_arvalid=0 or the wait counter equals SB_MAX_WAIT.
REQ-021 Wait counter SHALL increment on each demand grant while sb_arvalid=1, saturate at SB_MAX_WAIT, clear on sb grant or sb_arvalid=0.
REQ-022 ADDR: m_arvalid=1 with latched m_araddr/m_arlen and m_arid = 0 (ic), 1 (dc), 2 (sb); values stable until m_arready; m_arready=1 -> DATA.
REQ-023 DATA: m_rready=1; beat counter loaded with arlen; each m_rvalid asserts owner's <p>_rvalid, rdata=m_rdata, same cycle (zero latency); counter decrements.
REQ-024 Beat with counter=0 SHALL assert owner's <p>_rlast and move to IDLE; new arbitration possible the next cycle (one idle cycle minimum between bursts).
REQ-025 sb_abort=1 while owner=sb in ADDR or DATA: abort flag set; address handshake still completes; remaining beats drained with m_rready=1 and sb_rvalid/sb_rlast suppressed; flag cleared on return to IDLE.
REQ-026 sb_abort for a non-sb owner or in IDLE SHALL be ignored.
REQ-027 m_rvalid outside DATA SHALL be ignored; m_rready=0 outside DATA.
REQ-028 <p>_arvalid changes during ADDR/DATA SHALL not affect the in-flight burst; only one outstanding burst at any time.
REQ-029 arlen=0 SHALL give a single beat with rlast asserted.

Reset
REQ-030 rst_n low, at any state: state IDLE, all outputs 0 (m_arvalid, m_rready, every <p>_arready/<p>_rvalid/<p>_rlast, m_araddr, m_arlen, m_arid, rdata), RR pointer to ic, wait counter 0, abort flag 0, immediately and asynchronously.
REQ-031 Reset release SHALL allow arbitration on the first rising clk edge with rst_n high.

Verification
REQ-032 ic_arvalid, ic_araddr=0x1000, arlen=3; m_arready after 2 cycles; 4 beats -> m_arid=0, m_araddr=0x1000, 4 ic_rvalid, ic_rlast on beat 4, IDLE next cycle.
REQ-033 ic and dc held valid, 4 bursts -> grant order ic, dc, ic, dc.
REQ-034 sb and dc valid continuously, SB_MAX_WAIT=16 -> sb loses 16 arbitrations, wins the 17th with m_arid=2, counter returns 0.
REQ-035 sb burst arlen=7, sb_abort after beat 2 -> beats 3-8 accepted (m_rready=1), sb_rvalid low, next grant after beat 8.
REQ-036 rst_n low in DATA mid-burst -> all outputs 0 same cycle; after release, dc request with arlen=0 -> one beat, dc_rlast=1.

Source files
------------

// File: rtl/mem_read_arbiter.sv
// Read-channel arbiter: shares one memory read port between I-cache refill,
// D-cache refill and stream-buffer prefetch. One burst is outstanding at a time.
module mem_read_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int SB_MAX_WAIT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ic_arvalid,
    input  logic [ADDR_WIDTH-1:0] ic_araddr,
    input  logic [7:0]            ic_arlen,
    output logic                  ic_arready,
    output logic                  ic_rvalid,
    output logic                  ic_rlast,
    input  logic                  dc_arvalid,
    input  logic [ADDR_WIDTH-1:0] dc_araddr,
    input  logic [7:0]            dc_arlen,
    output logic                  dc_arready,
    output logic                  dc_rvalid,
    output logic                  dc_rlast,
    input  logic                  sb_arvalid,
    input  logic [ADDR_WIDTH-1:0] sb_araddr,
    input  logic [7:0]            sb_arlen,
    output logic                  sb_arready,
    output logic                  sb_rvalid,
    output logic                  sb_rlast,
    input  logic                  sb_abort,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]            m_arlen,
    output logic [3:0]            m_arid,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic                  m_rvalid,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    output logic                  m_rready
);

    localparam int WaitW = $clog2(SB_MAX_WAIT + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(SB_MAX_WAIT);

    localparam logic [1:0] OwnIc = 2'd0;
    localparam logic [1:0] OwnDc = 2'd1;
    localparam logic [1:0] OwnSb = 2'd2;

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [7:0]            beat_q;
    logic [1:0]            owner_q;
    logic                  rr_q;      // 0: ic next, 1: dc next
    logic [WaitW-1:0]      wait_q;
    logic                  abort_q;

    logic                  gnt_ic, gnt_dc, gnt_sb, gnt_any;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [7:0]            sel_len;
    logic [1:0]            sel_owner;
    logic                  beat, deliver, last;

    // Combinational winner selection; rst_n gates grants so arready stays low in reset
    always_comb begin
        gnt_ic    = 1'b0;
        gnt_dc    = 1'b0;
        gnt_sb    = 1'b0;
        sel_addr  = ic_araddr;
        sel_len   = ic_arlen;
        sel_owner = OwnIc;
        if (state_q == StIdle && rst_n) begin
            if (sb_arvalid && (!(ic_arvalid || dc_arvalid) || wait_q == WaitMax)) begin
                gnt_sb = 1'b1;
            end else if (ic_arvalid && dc_arvalid) begin
                gnt_dc = rr_q;
                gnt_ic = !rr_q;
            end else begin
                gnt_ic = ic_arvalid;
                gnt_dc = dc_arvalid;
            end
        end
        if (gnt_dc) begin
            sel_addr  = dc_araddr;
            sel_len   = dc_arlen;
            sel_owner = OwnDc;
        end else if (gnt_sb) begin
            sel_addr  = sb_araddr;
            sel_len   = sb_arlen;
            sel_owner = OwnSb;
        end
        gnt_any = gnt_ic || gnt_dc || gnt_sb;
    end

    // Burst sequencing: address phase, then data phase until the last beat
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (gnt_any) state_d = StAddr;
            StAddr:  if (m_arready) state_d = StData;
            StData:  if (m_rvalid && beat_q == 8'd0) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State, latched request, fairness and abort bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            owner_q <= OwnIc;
            rr_q    <= 1'b0;
            wait_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (gnt_any) begin
                addr_q  <= sel_addr;
                len_q   <= sel_len;
                beat_q  <= sel_len;
                owner_q <= sel_owner;
            end else if (beat && beat_q != 8'd0) begin
                beat_q <= beat_q - 8'd1;
            end
            if (gnt_ic) rr_q <= 1'b1;
            if (gnt_dc) rr_q <= 1'b0;
            if (!sb_arvalid || gnt_sb) begin
                wait_q <= '0;
            end else if ((gnt_ic || gnt_dc) && wait_q != WaitMax) begin
                wait_q <= wait_q + 1'b1;
            end
            if (state_q == StIdle) begin
                abort_q <= 1'b0;
            end else if (sb_abort && owner_q == OwnSb) begin
                abort_q <= 1'b1;
            end
        end
    end

    // Outputs: beats forwarded with zero latency, suppressed once a prefetch is aborted
    always_comb begin
        beat       = (state_q == StData) && m_rvalid;
        deliver    = beat && !abort_q;
        last       = deliver && (beat_q == 8'd0);
        ic_arready = gnt_ic;
        dc_arready = gnt_dc;
        sb_arready = gnt_sb;
        ic_rvalid  = deliver && owner_q == OwnIc;
        dc_rvalid  = deliver && owner_q == OwnDc;
        sb_rvalid  = deliver && owner_q == OwnSb;
        ic_rlast   = last && owner_q == OwnIc;
        dc_rlast   = last && owner_q == OwnDc;
        sb_rlast   = last && owner_q == OwnSb;
        rdata      = deliver ? m_rdata : '0;
        m_arvalid  = (state_q == StAddr);
        m_rready   = (state_q == StData);
        m_araddr   = addr_q;
        m_arlen    = len_q;
        m_arid     = {2'b00, owner_q};
    end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter: single burst, round-robin, stream-buffer
// starvation limit, prefetch abort and mid-burst reset.
module tb_mem_read_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ic_arvalid, dc_arvalid, sb_arvalid, sb_abort;
    logic [31:0] ic_araddr, dc_araddr, sb_araddr;
    logic [7:0]  ic_arlen, dc_arlen, sb_arlen;
    logic        ic_arready, dc_arready, sb_arready;
    logic        ic_rvalid, dc_rvalid, sb_rvalid;
    logic        ic_rlast, dc_rlast, sb_rlast;
    logic [31:0] rdata, m_araddr, m_rdata;
    logic [7:0]  m_arlen;
    logic [3:0]  m_arid;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;

    int tests = 0;
    int fails = 0;

    mem_read_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SB_MAX_WAIT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_arvalid(ic_arvalid), .ic_araddr(ic_araddr), .ic_arlen(ic_arlen),
        .ic_arready(ic_arready), .ic_rvalid(ic_rvalid), .ic_rlast(ic_rlast),
        .dc_arvalid(dc_arvalid), .dc_araddr(dc_araddr), .dc_arlen(dc_arlen),
        .dc_arready(dc_arready), .dc_rvalid(dc_rvalid), .dc_rlast(dc_rlast),
        .sb_arvalid(sb_arvalid), .sb_araddr(sb_araddr), .sb_arlen(sb_arlen),
        .sb_arready(sb_arready), .sb_rvalid(sb_rvalid), .sb_rlast(sb_rlast),
        .sb_abort(sb_abort), .rdata(rdata),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arid(m_arid),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rready(m_rready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " arready"}, {sb_arready, dc_arready, ic_arready}, 0);
        chk({tag, " rvalid"}, {sb_rvalid, dc_rvalid, ic_rvalid}, 0);
        chk({tag, " rlast"}, {sb_rlast, dc_rlast, ic_rlast}, 0);
        chk({tag, " m_arvalid/m_rready"}, {m_arvalid, m_rready}, 0);
        chk({tag, " m_araddr"}, m_araddr, 0);
        chk({tag, " m_arlen/m_arid"}, {m_arlen, m_arid}, 0);
        chk({tag, " rdata"}, rdata, 0);
    endtask

    // Called inside an idle cycle with requests already driven; returns in the
    // idle cycle following the last beat.
    task automatic do_burst(input int owner, input logic [31:0] addr, input int len,
                            input int abort_beat, input int ar_delay, input bit keep);
        bit   aborted;
        logic rv, rl;
        #1;
        chk("grant", {sb_arready, dc_arready, ic_arready}, 3'b001 << owner);
        chk("idle m_arvalid", m_arvalid, 0);
        @(posedge clk); #1;
        if (!keep) begin
            ic_arvalid = 0; dc_arvalid = 0; sb_arvalid = 0;
        end
        #1;
        chk("addr m_arvalid", m_arvalid, 1);
        chk("addr m_araddr", m_araddr, addr);
        chk("addr m_arlen", m_arlen, len);
        chk("addr m_arid", m_arid, owner);
        chk("addr no grant", {sb_arready, dc_arready, ic_arready}, 0);
        for (int d = 0; d < ar_delay; d++) begin
            @(posedge clk); #2;
            chk("addr hold", {m_arvalid, m_araddr}, {1'b1, addr});
        end
        m_arready = 1;
        @(posedge clk); #1;
        m_arready = 0;
        aborted = 0;
        for (int i = 0; i <= len; i++) begin
            if (i == abort_beat) begin
                sb_abort = 1;
                @(posedge clk); #1;
                sb_abort = 0;
                aborted = 1;
            end
            m_rvalid = 1;
            m_rdata  = 32'hA500_0000 | (owner << 8) | i;
            #1;
            case (owner)
                0:       begin rv = ic_rvalid; rl = ic_rlast; end
                1:       begin rv = dc_rvalid; rl = dc_rlast; end
                default: begin rv = sb_rvalid; rl = sb_rlast; end
            endcase
            chk("data m_rready", m_rready, 1);
            chk("data rvalid", rv, !aborted);
            chk("data rlast", rl, !aborted && i == len);
            if (!aborted) chk("data rdata", rdata, m_rdata);
            @(posedge clk); #1;
            m_rvalid = 0;
        end
        #1;
        chk("post m_rready", m_rready, 0);
        chk("post m_arvalid", m_arvalid, 0);
    endtask

    initial begin
        rst_n = 0;
        ic_arvalid = 1; dc_arvalid = 0; sb_arvalid = 1; sb_abort = 0;
        ic_araddr = 0; dc_araddr = 0; sb_araddr = 0;
        ic_arlen = 0; dc_arlen = 0; sb_arlen = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = 0;
        #3;
        chk_zero("reset");

        // Single ic burst, address accepted after two wait cycles
        @(posedge clk); #1;
        rst_n = 1;
        sb_arvalid = 0;
        ic_araddr = 32'h1000; ic_arlen = 8'd3;
        do_burst(0, 32'h1000, 3, -1, 2, 0);
        chk("idle after ic", {sb_arready, dc_arready, ic_arready}, 0);

        // Round-robin from a fresh pointer
        rst_n = 0; #1; rst_n = 1;
        ic_arvalid = 1; dc_arvalid = 1;
        ic_araddr = 32'h2000; dc_araddr = 32'h2100;
        ic_arlen = 8'd1; dc_arlen = 8'd1;
        do_burst(0, 32'h2000, 1, -1, 0, 1);
        do_burst(1, 32'h2100, 1, -1, 0, 1);
        do_burst(0, 32'h2000, 1, -1, 0, 1);
        do_burst(1, 32'h2100, 1, -1, 0, 0);

        // Stream buffer loses 16 times to dc, then wins; then aborted mid-burst
        dc_arvalid = 1; sb_arvalid = 1;
        dc_araddr = 32'h3100; dc_arlen = 8'd0;
        sb_araddr = 32'h3000; sb_arlen = 8'd7;
        for (int k = 0; k < 16; k++) do_burst(1, 32'h3100, 0, -1, 0, 1);
        do_burst(2, 32'h3000, 7, 2, 0, 1);
        // Counter cleared by the sb grant, so demand wins again
        do_burst(1, 32'h3100, 0, -1, 0, 0);

        // Reset asserted while a dc beat is on the bus
        dc_arvalid = 1; dc_araddr = 32'h4000; dc_arlen = 8'd3;
        #1;
        chk("mid grant", dc_arready, 1);
        @(posedge clk); #1;
        dc_arvalid = 0; m_arready = 1;
        @(posedge clk); #1;
        m_arready = 0; m_rvalid = 1; m_rdata = 32'hDEAD_BEEF;
        #1;
        chk("mid beat", {dc_rvalid, rdata}, {1'b1, 32'hDEAD_BEEF});
        rst_n = 0;
        #1;
        chk_zero("mid reset");
        @(posedge clk); #1;
        m_rvalid = 0; rst_n = 1;
        dc_arvalid = 1; dc_araddr = 32'h5000; dc_arlen = 8'd0;
        do_burst(1, 32'h5000, 0, -1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
